// File: rtl/sha256_pkg.sv
// sha256_pkg: shared state encoding, block geometry and last-word padding helpers for the SHA-256 stream controller
package sha256_pkg;

    typedef enum logic [2:0] {IDLE, FILL, PAD, LEN, ISSUE, WAIT, DONE} state_t;

    localparam int BLOCK_WORDS = 16;
    localparam int LEN_WORD_IDX = 14;
    localparam logic [31:0] PAD_MARKER = 32'h8000_0000;

    // keeps the k MSB-aligned message bytes of a final word; k=0 means all four
    function automatic logic [31:0] byte_mask(input logic [1:0] k);
        return k == 2'd0 ? 32'hFFFF_FFFF : ~(32'hFFFF_FFFF >> {k, 3'b000});
    endfunction

    function automatic logic [31:0] pad_last_word(input logic [31:0] data, input logic [1:0] k);
        return k == 2'd0 ? data : (data & byte_mask(k)) | (PAD_MARKER >> {k, 3'b000});
    endfunction

endpackage

// File: rtl/sha256_block_buf.sv
// sha256_block_buf: 16x32 message block register file with indexed write, length-field write and clear
module sha256_block_buf
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         wr_en,
    input  logic [3:0]   wr_idx,
    input  logic [31:0]  wr_data,
    input  logic         len_en,
    input  logic [63:0]  len_data,
    output logic [511:0] block
);

    logic [31:0] mem [BLOCK_WORDS];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int j = 0; j < BLOCK_WORDS; j++) mem[j] <= '0;
        end else if (clr) begin
            for (int j = 0; j < BLOCK_WORDS; j++) mem[j] <= '0;
        end else begin
            if (wr_en) mem[wr_idx] <= wr_data;
            if (len_en) begin
                mem[LEN_WORD_IDX]     <= len_data[63:32];
                mem[LEN_WORD_IDX + 1] <= len_data[31:0];
            end
        end
    end

    genvar i;
    for (i = 0; i < BLOCK_WORDS; i++) begin : g_word
        assign block[511 - 32 * i -: 32] = mem[i];
    end

endmodule

// File: rtl/sha256_stream_ctrl.sv
// sha256_stream_ctrl: word-stream front end that pads a message into 512-bit blocks and sequences sha256_core
module sha256_stream_ctrl
    import sha256_pkg::*;
#(
    parameter int LEN_W   = 64,
    parameter int HOLDOFF = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         mode,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         in_last,
    input  logic [1:0]   in_last_bytes,
    input  logic         empty_req,
    output logic         core_init,
    output logic         core_next,
    output logic         core_mode,
    output logic [511:0] core_block,
    input  logic         core_ready,
    input  logic [255:0] core_digest,
    input  logic         core_digest_valid,
    output logic [255:0] digest_out,
    output logic         digest_out_valid,
    input  logic         digest_out_ready,
    output logic         busy
);

    state_t           state, state_nx, fill_nx;
    logic [3:0]       idx;
    logic [LEN_W-1:0] byte_cnt, bit_len;
    logic [7:0]       hold_cnt;
    logic             mode_r, first_blk, final_r, pad_pending, marker_pending;
    logic             acc, empty_go, wait_done, last_short;
    logic [2:0]       acc_bytes;
    logic             buf_wr, buf_len_wr, buf_clr;
    logic [3:0]       buf_idx;
    logic [31:0]      buf_data;

    assign empty_go   = state == IDLE && empty_req;
    assign acc        = in_ready && in_valid && !empty_go;
    assign last_short = in_last && in_last_bytes != 2'd0;
    assign acc_bytes  = last_short ? {1'b0, in_last_bytes} : 3'd4;
    assign wait_done  = hold_cnt == 8'd0 && core_ready && (!final_r || core_digest_valid);
    assign bit_len    = byte_cnt << 3;
    assign core_mode  = mode_r;

    // a short last word already carries the marker, so with it at word 13 the length fits directly
    assign fill_nx = idx == 4'd15 ? ISSUE :
                     !in_last ? FILL :
                     (last_short && idx == 4'd13) ? LEN : PAD;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = empty_go ? PAD : acc ? fill_nx : IDLE;
            FILL:    state_nx = acc ? fill_nx : FILL;
            PAD:     state_nx = idx == 4'd13 ? LEN : idx == 4'd15 ? ISSUE : PAD;
            LEN:     state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    state_nx = !wait_done ? WAIT : final_r ? DONE : pad_pending ? PAD : FILL;
            DONE:    state_nx = digest_out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready         = reset_n && (state == IDLE || state == FILL);
        core_init        = state == ISSUE && first_blk;
        core_next        = state == ISSUE && !first_blk;
        digest_out_valid = state == DONE;
        busy             = state != IDLE;
        buf_wr           = acc || empty_go || state == PAD;
        buf_len_wr       = state == LEN;
        buf_clr          = state == DONE && digest_out_ready;
        buf_idx          = state == IDLE ? 4'd0 : idx;
        buf_data         = (empty_go || (state == PAD && marker_pending)) ? PAD_MARKER :
                           state == PAD ? 32'd0 :
                           in_last ? pad_last_word(in_data, in_last_bytes) : in_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx            <= '0;
            byte_cnt       <= '0;
            hold_cnt       <= '0;
            mode_r         <= 1'b0;
            first_blk      <= 1'b0;
            final_r        <= 1'b0;
            pad_pending    <= 1'b0;
            marker_pending <= 1'b0;
            digest_out     <= '0;
        end else begin
            if (empty_go) begin
                idx            <= 4'd1;
                byte_cnt       <= '0;
                mode_r         <= mode;
                first_blk      <= 1'b1;
                final_r        <= 1'b0;
                pad_pending    <= 1'b0;
                marker_pending <= 1'b0;
            end
            if (acc) begin
                idx            <= idx + 4'd1;
                byte_cnt       <= state == IDLE ? LEN_W'(acc_bytes) : byte_cnt + LEN_W'(acc_bytes);
                marker_pending <= in_last && !last_short;
                pad_pending    <= in_last && idx == 4'd15;
                if (state == IDLE) begin
                    mode_r    <= mode;
                    first_blk <= 1'b1;
                    final_r   <= 1'b0;
                end
            end
            // running past word 15 while padding means the length needs a block of its own
            if (state == PAD) begin
                idx            <= idx + 4'd1;
                marker_pending <= 1'b0;
                if (idx == 4'd15) pad_pending <= 1'b1;
            end
            if (state == LEN) final_r <= 1'b1;
            if (state == ISSUE) begin
                first_blk <= 1'b0;
                hold_cnt  <= 8'(HOLDOFF);
            end
            if (state == WAIT && hold_cnt != 8'd0) hold_cnt <= hold_cnt - 8'd1;
            if (state == WAIT && wait_done) begin
                idx         <= '0;
                pad_pending <= 1'b0;
                if (final_r) digest_out <= core_digest;
            end
            if (state == DONE && digest_out_ready) idx <= '0;
        end
    end

    sha256_block_buf u_buf (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (buf_clr),
        .wr_en    (buf_wr),
        .wr_idx   (buf_idx),
        .wr_data  (buf_data),
        .len_en   (buf_len_wr),
        .len_data (64'(bit_len)),
        .block    (core_block)
    );

endmodule
